// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM for the core's load/store port, plus a
// TOHOST status word that drives a RUN/PASS/FAIL/TIMEOUT run-status FSM.
// Optional feature: define DMEM_MMIO_WATCHDOG_EN to build a RUN-state cycle
// watchdog that forces TIMEOUT after WDOG_CYCLES cycles.
module dmem_mmio #(
  parameter int unsigned DEPTH       = 64,
  parameter logic [31:0] TOHOST_ADDR = 32'd100,
  parameter logic [31:0] PASS_VALUE  = 32'd25,
  parameter int unsigned WDOG_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [15:0] store_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] RAM_SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Elaboration-time parameter sanity.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_mmio: DEPTH must be a power of two >= 2");
  end
  if (WDOG_CYCLES == 0) begin : g_bad_wdog
    $error("dmem_mmio: WDOG_CYCLES must be nonzero");
  end

  state_t        state_q, state_d;
  logic [1:0]    err_q, err_d;
  logic [15:0]   count_q, count_d;
  logic          done_q, pass_q;
  logic          rst_meta, rst_sync_n;
  logic          active_q;
  logic          ram_we_c;
  logic          wdog_expired_c;
  logic [AW-1:0] idx_c;
  logic          misaligned_c, is_tohost_c, in_range_c;
  logic [31:0]   mem [DEPTH];

  assign idx_c        = DataAddr[AW+1:2];
  assign misaligned_c = (DataAddr[1:0] != 2'd0);
  assign is_tohost_c  = (DataAddr == TOHOST_ADDR);
  assign in_range_c   = (DataAddr < RAM_SPAN);

  // Reset: asserts asynchronously, releases through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Store-accept enable; drops to 0 the instant reset asserts so in-flight stores are lost.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) active_q <= 1'b0;
    else             active_q <= 1'b1;
  end

`ifdef DMEM_MMIO_WATCHDOG_EN
  logic [31:0] wdog_q;

  assign wdog_expired_c = (wdog_q >= 32'(WDOG_CYCLES - 1));

  // RUN-state cycle counter; holds at the expiry value until the FSM leaves RUN.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n)                            wdog_q <= 32'd0;
    else if (state_q == ST_RUN && !wdog_expired_c) wdog_q <= wdog_q + 32'd1;
  end
`else
  assign wdog_expired_c = 1'b0;
`endif

  // State, status and counter registers.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_RUN;
      err_q   <= 2'd0;
      count_q <= 16'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      count_q <= count_d;
      done_q  <= (state_d != ST_RUN);
      pass_q  <= (state_d == ST_PASS);
    end
  end

  // Store decode and next state; a store in RUN takes precedence over watchdog expiry.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    count_d  = count_q;
    ram_we_c = 1'b0;
    if (state_q == ST_RUN) begin
      if (MemWrite && active_q) begin
        if (misaligned_c) begin
          state_d = ST_FAIL;
          err_d   = 2'd2;
        end else if (is_tohost_c) begin
          if (WriteData == PASS_VALUE) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_FAIL;
            err_d   = 2'd1;
          end
        end else if (!in_range_c) begin
          state_d = ST_FAIL;
          err_d   = 2'd2;
        end else begin
          ram_we_c = 1'b1;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end
      end else if (wdog_expired_c) begin
        state_d = ST_TIMEOUT;
        err_d   = 2'd3;
      end
    end
  end

  // Data RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (ram_we_c) mem[idx_c] <= WriteData;
  end

  // Combinational load path: TOHOST status, then RAM, else zero.
  always_comb begin
    ReadData = 32'h0;
    if (is_tohost_c)     ReadData = {30'b0, state_q};
    else if (in_range_c) ReadData = mem[idx_c];
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign err_code    = err_q;
  assign store_count = count_q;

endmodule
